hex_display_scanner: RTL and testbench
======================================

# hex_display_scanner

Time-multiplexed controller for the board's common-anode seven-segment bank. It holds a signed-magnitude hex value, sequences a single shared hex-to-segment decode across `DIGITS` digit positions, and drives active-low anode enables. Between digits it inserts an anti-ghosting blank interval. It also applies leading-zero suppression and places the negative sign on the lowest suppressed digit. It sits between the calculator result path and the board display pins.

## Interface
- `DIGITS`, 4: number of digit positions; legal range 2..8.
- `PRESCALE`, 50000: clocks each digit is lit; must be ≥ 1.
- `BLANK_CYCLES`, 500: clocks with all anodes off after each digit; must be ≥ 0, and 0 removes the blank phase.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous and active-low.
- `load` in 1: one-cycle strobe that captures `value` and `neg`.
- `value` in 4*DIGITS: magnitude as hex nibbles; nibble 0 is the rightmost digit.
- `neg` in 1: 1 means the value is negative and a minus sign is shown.
- `seg` out 7: active-low segments, `seg[6]`=a … `seg[0]`=g.
- `an` out DIGITS: active-low anode enables; `an[i]` drives digit i.
- `frame_done` out 1: one-cycle pulse when a full scan completes.
- `sign_lost` out 1: high while the displayed value is negative but has no free digit for the sign.

## Operation
- Registers:
  - `shadow_val`/`shadow_neg` plus a `pending` flag.
  - `disp_val`/`disp_neg`, which drive the decode.
  - Digit index `idx` (0..DIGITS-1), phase counter, and FSM state.
- Load handling:
  - `load`=1 writes the shadow registers and sets `pending`.
  - `disp_*` is updated only at the frame boundary: when `idx` wraps from DIGITS-1 to 0, `disp_* <= shadow_*` if `pending`, and `pending` is cleared.
  - `load` coinciding with the boundary: the boundary copies the old shadow; the new value lands in the shadow and `pending` stays 1, so it is applied at the next boundary.
  - Back-to-back loads within one frame: the last one wins.
- FSM states: `SHOW` and `BLANK`.
  - `SHOW` lasts PRESCALE cycles, then goes to `BLANK`; if BLANK_CYCLES=0 it goes directly to `SHOW` of the next idx.
  - `BLANK` lasts BLANK_CYCLES cycles, then goes to `SHOW` with idx+1 modulo DIGITS.
- Digit suppression:
  - Digit i>0 is suppressed when nibbles i..DIGITS-1 of `disp_val` are all zero.
  - Digit 0 is never suppressed.
- Sign placement:
  - If `disp_neg`, the lowest suppressed digit shows minus (7'b1111110).
  - If no digit is suppressed, the sign is not drawn and `sign_lost`=1.
  - All other suppressed digits are blank (7'h7F).
- Decode, active-low gfedcba mapped onto `seg[6:0]`=a..g:
  - 0: 0000001; 1: 1001111; 2: 0010010; 3: 0000110.
  - 4: 1001100; 5: 0100100; 6: 0100000; 7: 0001111.
  - 8: 0000000; 9: 0000100; A: 0001000; b: 1100000.
  - C: 0110001; d: 1000010; E: 0110000; F: 0111000.
- Outputs during the two phases:
  - `SHOW`: `an` = ~(1<<idx), `seg` = digit content.
  - `BLANK`: `an` = all ones, `seg` = 7'h7F.
- `frame_done` pulses in the cycle the boundary copy occurs.

## Timing
- Reset values:
  - Outputs: `an` all ones, `seg`=7'h7F, `frame_done`=0, `sign_lost`=0.
  - Internal: `disp_val`=0, `disp_neg`=0, `shadow` 0, `pending`=0, idx=0, state `SHOW`, counter 0.
- `seg`, `an`, `frame_done` and `sign_lost` are registered, one cycle behind the FSM state.
- Startup: the first rising edge after `rst_n` deasserts lights digit 0 (`an`=…1110, `seg`=0000001).
- Each digit is lit for exactly PRESCALE cycles, followed by BLANK_CYCLES cycles of all-off.
- Frame period = DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
- Latency from `load` to display is between 1 frame (load just after a boundary) and 1 cycle past the next boundary. The new value first appears on digit 0 of the new frame.
- `sign_lost` updates with `disp_*` at the boundary.
- `rst_n` assertion mid-frame forces all reset values immediately; any pending load is discarded.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
- **Reset and scan:** release reset with no load → `an` steps 1110×4, 1111, 1101×4, 1111, …; `frame_done` pulses every 20 cycles; digit 0 `seg`=0000001 and other digits 7'h7F.
- **Full value:** load `value`=16'h12AF, `neg`=0 → after the next boundary, digit 0..3 `seg` = 0111000, 0001000, 0010010, 1001111; `sign_lost`=0.
- **Negative with suppression:** load 16'h0005, `neg`=1 → digit 0 = 0100100, digit 1 = 1111110, digits 2..3 = 7'h7F; `sign_lost`=0.
- **Negative without room:** load 16'h8000, `neg`=1 → digit 3 = 0000000, digits 0..2 = 0000001, no minus shown; `sign_lost`=1.
- **Boundary race:** load A mid-frame, then load B in the same cycle as the boundary → A is displayed this frame; B appears after the next boundary; `frame_done` pulses both times.
- **Reset mid-frame:** assert `rst_n`=0 during digit 2 `SHOW` with a load pending → `an`=1111 and `seg`=7'h7F asynchronously; after release the scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Time-multiplexed seven-segment scanner for a common-anode bank with
// frame-aligned value updates, leading-zero suppression and sign placement.
module hex_display_scanner #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  neg,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  sign_lost
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(DIGITS);

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            4'hF:    pat = 7'b0111000;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    state_t                state_r, state_nx_s;
    logic [IW-1:0]         idx_r, idx_nx_s;
    logic [CW-1:0]         cnt_r, cnt_nx_s;
    logic                  advance_s;
    logic                  boundary_s;

    logic [4*DIGITS-1:0]   shadow_val_r;
    logic                  shadow_neg_r;
    logic                  pending_r;
    logic [4*DIGITS-1:0]   disp_val_r, disp_val_nx_s;
    logic                  disp_neg_r, disp_neg_nx_s;

    logic [DIGITS-1:0]     supp_s;
    logic [DIGITS-1:0]     lowest_s;
    logic [6:0]            pat_s [DIGITS];
    logic [6:0]            seg_s;
    logic [DIGITS-1:0]     an_s;
    logic                  sign_lost_s;

    logic [6:0]            seg_r;
    logic [DIGITS-1:0]     an_r;
    logic                  frame_done_r;
    logic                  sign_lost_r;

    // Scan FSM state, digit index and phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SHOW;
            idx_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state: a zero-length blank phase skips straight to the next digit
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cnt_nx_s   = cnt_r + CW'(1);
        advance_s  = 1'b0;
        case (state_r)
            SHOW: begin
                if (cnt_r == CW'(PRESCALE - 1)) begin
                    cnt_nx_s = '0;
                    if (BLANK_CYCLES == 0) begin
                        advance_s = 1'b1;
                    end else begin
                        state_nx_s = BLANK;
                    end
                end else begin
                    state_nx_s = SHOW;
                end
            end
            BLANK: begin
                if (cnt_r == CW'(BLANK_CYCLES - 1)) begin
                    cnt_nx_s   = '0;
                    state_nx_s = SHOW;
                    advance_s  = 1'b1;
                end else begin
                    state_nx_s = BLANK;
                end
            end
            default: begin
                state_nx_s = SHOW;
                cnt_nx_s   = '0;
            end
        endcase
        boundary_s = advance_s && (idx_r == IW'(DIGITS - 1));
        if (advance_s) begin
            idx_nx_s = boundary_s ? '0 : idx_r + IW'(1);
        end else begin
            idx_nx_s = idx_r;
        end
    end

    assign disp_val_nx_s = (boundary_s && pending_r) ? shadow_val_r : disp_val_r;
    assign disp_neg_nx_s = (boundary_s && pending_r) ? shadow_neg_r : disp_neg_r;

    // Shadow capture and frame-aligned transfer; a load on the boundary stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_r <= '0;
            shadow_neg_r <= 1'b0;
            pending_r    <= 1'b0;
            disp_val_r   <= '0;
            disp_neg_r   <= 1'b0;
        end else begin
            disp_val_r <= disp_val_nx_s;
            disp_neg_r <= disp_neg_nx_s;
            if (load) begin
                shadow_val_r <= value;
                shadow_neg_r <= neg;
                pending_r    <= 1'b1;
            end else if (boundary_s) begin
                pending_r    <= 1'b0;
            end else begin
                pending_r    <= pending_r;
            end
        end
    end

    // Leading-zero suppression mask; digit 0 is always shown
    always_comb begin : suppress_blk
        logic all_zero;
        all_zero = 1'b1;
        supp_s   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero  = all_zero & (disp_val_r[4*i +: 4] == 4'h0);
            supp_s[i] = all_zero;
        end
    end

    // The mask is monotonic upward, so its lowest set bit is where the sign goes
    assign lowest_s    = supp_s & ~{supp_s[DIGITS-2:0], 1'b0};
    assign sign_lost_s = disp_neg_nx_s && (disp_val_nx_s[4*DIGITS-1 -: 4] != 4'h0);

    // Per-digit content
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            if (!supp_s[i]) begin
                pat_s[i] = hex_to_seg(disp_val_r[4*i +: 4]);
            end else if (disp_neg_r && lowest_s[i]) begin
                pat_s[i] = 7'b1111110;
            end else begin
                pat_s[i] = 7'h7F;
            end
        end
    end

    // Phase-dependent drive values
    always_comb begin
        an_s  = '1;
        seg_s = 7'h7F;
        case (state_r)
            SHOW: begin
                an_s  = ~(DIGITS'(1) << idx_r);
                seg_s = pat_s[idx_r];
            end
            BLANK: begin
                an_s  = '1;
                seg_s = 7'h7F;
            end
            default: begin
                an_s  = '1;
                seg_s = 7'h7F;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r        <= 7'h7F;
            an_r         <= '1;
            frame_done_r <= 1'b0;
            sign_lost_r  <= 1'b0;
        end else begin
            seg_r        <= seg_s;
            an_r         <= an_s;
            frame_done_r <= boundary_s;
            sign_lost_r  <= sign_lost_s;
        end
    end

    assign seg        = seg_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;
    assign sign_lost  = sign_lost_r;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: a frame-level reference model
// queues expected pin values each cycle; a negedge monitor compares them.
module tb_hex_display_scanner;

    localparam int D = 4;
    localparam int P = 4;
    localparam int B = 1;
    localparam int FRAME = D * (P + B);

    logic            clk;
    logic            rst_n;
    logic            load;
    logic [4*D-1:0]  value;
    logic            neg;
    logic [6:0]      seg;
    logic [D-1:0]    an;
    logic            frame_done;
    logic            sign_lost;

    int checks = 0;
    int errors = 0;
    int n      = 0;

    typedef struct {
        logic [D-1:0] an;
        logic [6:0]   seg;
        logic         fd;
        logic         sl;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [4*D-1:0] m_shadow, m_disp;
    logic           m_shadow_neg, m_disp_neg, m_pend;

    hex_display_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .neg(neg),
        .seg(seg), .an(an), .frame_done(frame_done), .sign_lost(sign_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_digit(logic [4*D-1:0] v, logic ng, int d);
        int h;
        h = 0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] != 4'h0) h = i;
        if (d <= h) return seg_tab[v[4*d +: 4]];
        if (ng && d == h + 1) return 7'b1111110;
        return 7'h7F;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    // Reference model: one expected output set per rising edge
    initial begin
        logic [4*D-1:0] old_val;
        logic           old_neg;
        logic [D-1:0]   one;
        int             pos, d;
        exp_t           e;
        one = 4'b0001;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n = 0;
                m_shadow = '0; m_disp = '0; m_shadow_neg = 1'b0;
                m_disp_neg = 1'b0; m_pend = 1'b0;
                exp_q.delete();
            end else begin
                n++;
                old_val = m_disp;
                old_neg = m_disp_neg;
                if (n % FRAME == 0 && m_pend) begin
                    m_disp = m_shadow; m_disp_neg = m_shadow_neg; m_pend = 1'b0;
                end
                if (load) begin
                    m_shadow = value; m_shadow_neg = neg; m_pend = 1'b1;
                end
                pos = (n - 1) % FRAME;
                d   = pos / (P + B);
                if (pos % (P + B) < P) begin
                    e.an  = ~(one << d);
                    e.seg = exp_digit(old_val, old_neg, d);
                end else begin
                    e.an  = '1;
                    e.seg = 7'h7F;
                end
                e.fd = (n % FRAME == 0);
                e.sl = m_disp_neg && (m_disp[4*D-1 -: 4] != 4'h0);
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT pins against the queue on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || exp_q.size() == 0) begin
                if (rst_n && n > 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty at n=%0d: got 0 entries required 1", n);
                end
                check("reset_an", 32'(an), 32'hF);
                check("reset_seg", 32'(seg), 32'h7F);
                check("reset_fd", 32'(frame_done), 32'h0);
                check("reset_sl", 32'(sign_lost), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("an", 32'(an), 32'(e.an));
                check("seg", 32'(seg), 32'(e.seg));
                check("frame_done", 32'(frame_done), 32'(e.fd));
                check("sign_lost", 32'(sign_lost), 32'(e.sl));
            end
        end
    end

    task automatic tick(int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(logic [4*D-1:0] v, logic ng);
        load = 1'b1; value = v; neg = ng;
        tick(1);
        load = 1'b0;
    endtask

    task automatic wait_phase(int target);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (n % FRAME == target) return;
            tick(1);
        end
        errors++;
        $display("FAIL wait_phase timeout: got n=%0d required phase %0d", n, target);
    endtask

    initial begin
        logic [4*D-1:0] rv;
        rst_n = 1'b0; load = 1'b0; value = '0; neg = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(45);

        do_load(16'h12AF, 1'b0); tick(45);
        do_load(16'h0005, 1'b1); tick(45);
        do_load(16'h8000, 1'b1); tick(45);
        do_load(16'h0000, 1'b1); tick(45);

        // Boundary race: A mid-frame, B sampled on the boundary edge
        wait_phase(10);
        do_load(16'h00A1, 1'b0);
        wait_phase(19);
        do_load(16'h0B02, 1'b1);
        tick(45);

        for (int k = 0; k < 12; k++) begin
            rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            do_load(rv, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) do_load(16'($urandom), 1'($urandom_range(0, 1)));
            tick($urandom_range(1, 30));
        end
        tick(45);

        // Reset during digit 2 with a load pending
        wait_phase(5);
        do_load(16'h4321, 1'b1);
        wait_phase(12);
        rst_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hF);
        check("async_seg", 32'(seg), 32'h7F);
        tick(2);
        rst_n = 1'b1;
        tick(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
